rs_multi_cdb: RTL

Parametrised reservation station for the integer execution path, sitting between the dispatcher and the ALU. It holds up to DEPTH waiting instructions and wakes operands from NUM_CDB result buses. Operands broadcast in the same cycle as dispatch are captured directly, with no lost wakeup. Ready entries issue over a valid/ready handshake, so the ALU can stall the station.

---
 rtl/rs_multi_cdb_pkg.sv | 29 ++
 rtl/rs_multi_cdb_select.sv | 44 ++++
 rtl/rs_multi_cdb.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rs_multi_cdb_pkg.sv
// ---------------------------------------------------------------------------
// rs_multi_cdb_pkg
// Shared defines for the integer execution path: default widths, the NOP
// opcode, the "no dependency" ROB tag and the opcode enumeration used by the
// execution units. Imported by rs_multi_cdb and rs_multi_cdb_select.
// ---------------------------------------------------------------------------
package rs_multi_cdb_pkg;

  localparam int unsigned DEPTH_DEF    = 16;
  localparam int unsigned NUM_CDB_DEF  = 2;
  localparam int unsigned DATA_W_DEF   = 32;
  localparam int unsigned ADDR_W_DEF   = 32;
  localparam int unsigned ROB_W_DEF    = 5;
  localparam int unsigned OPENUM_W_DEF = 6;

  // Kept as plain integers so every user casts them to its own width.
  localparam int unsigned OPENUM_NOP = 0;
  localparam int unsigned ZERO_ROB   = 0;

  typedef enum logic [OPENUM_W_DEF-1:0] {
    OP_NOP = 6'd0,
    OP_ADD = 6'd1,
    OP_SUB = 6'd2,
    OP_AND = 6'd3,
    OP_OR  = 6'd4,
    OP_XOR = 6'd5
  } openum_e;

endpackage

// File: rtl/rs_multi_cdb_select.sv
// ---------------------------------------------------------------------------
// rs_multi_cdb_select (the reservation-station issue selector, rs_select)
// Combinational: picks one ready entry and returns it as a one-hot grant.
//   age_i   : DEPTH x DEPTH age matrix, row i at [i*DEPTH +: DEPTH]; bit j of
//             row i set means entry j is older than entry i
//             (port exists only when RS_OLDEST_FIRST_EN is defined)
//   ready_i : per-entry ready vector
//   grant_o : one-hot grant (all zero when nothing is ready)
//   valid_o : at least one entry is ready
// Macro RS_OLDEST_FIRST_EN: defined -> oldest ready entry wins;
//                           undefined -> lowest-index ready entry wins.
// ---------------------------------------------------------------------------
module rs_multi_cdb_select
  import rs_multi_cdb_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF
) (
`ifdef RS_OLDEST_FIRST_EN
  input  logic [DEPTH*DEPTH-1:0] age_i,
`endif
  input  logic [DEPTH-1:0]       ready_i,
  output logic [DEPTH-1:0]       grant_o,
  output logic                   valid_o
);

  assign valid_o = |ready_i;

`ifdef RS_OLDEST_FIRST_EN
  // Grant the ready entry that has no older ready entry; the age relation is
  // a total order over busy entries, so exactly one entry qualifies.
  always_comb begin
    grant_o = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      grant_o[i] = ready_i[i] & ~(|(ready_i & age_i[i*DEPTH +: DEPTH]));
    end
  end
`else
  // Isolate the lowest set bit of the ready vector.
  always_comb begin
    grant_o = ready_i & (~ready_i + DEPTH'(1));
  end
`endif

endmodule

// File: rtl/rs_multi_cdb.sv
// ---------------------------------------------------------------------------
// rs_multi_cdb
// Reservation station between the dispatcher and the ALU. Holds DEPTH
// entries, wakes operands from NUM_CDB result buses (including operands
// broadcast in the dispatch cycle), and issues ready entries through a
// registered valid/ready output stage.
// Ports:
//   clk_i, rst_ni            : clock, synchronous active-low reset
//   flush_i                  : mispredict flush (empties station and output)
//   disp_*_i                 : dispatch request and instruction fields
//   full_o, count_o          : no free entry / occupied entry count
//   cdb_valid_i/rob_id_i/result_i : flattened broadcast channels, ch0 in LSBs
//   ex_valid_o, ex_ready_i   : issue handshake to the ALU
//   ex_*_o                   : issued instruction fields
// Macro RS_OLDEST_FIRST_EN: defined -> age matrix kept, oldest ready issues;
//                           undefined -> lowest-index ready issues.
// ---------------------------------------------------------------------------
module rs_multi_cdb
  import rs_multi_cdb_pkg::*;
#(
  parameter int unsigned DEPTH    = DEPTH_DEF,
  parameter int unsigned NUM_CDB  = NUM_CDB_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned ROB_W    = ROB_W_DEF,
  parameter int unsigned OPENUM_W = OPENUM_W_DEF
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       disp_valid_i,
  input  logic [OPENUM_W-1:0]        disp_openum_i,
  input  logic [DATA_W-1:0]          disp_v1_i,
  input  logic [DATA_W-1:0]          disp_v2_i,
  input  logic [ROB_W-1:0]           disp_q1_i,
  input  logic [ROB_W-1:0]           disp_q2_i,
  input  logic [ADDR_W-1:0]          disp_pc_i,
  input  logic [DATA_W-1:0]          disp_imm_i,
  input  logic [ROB_W-1:0]           disp_rob_id_i,
  output logic                       full_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  input  logic [NUM_CDB-1:0]         cdb_valid_i,
  input  logic [NUM_CDB*ROB_W-1:0]   cdb_rob_id_i,
  input  logic [NUM_CDB*DATA_W-1:0]  cdb_result_i,
  output logic                       ex_valid_o,
  input  logic                       ex_ready_i,
  output logic [OPENUM_W-1:0]        ex_openum_o,
  output logic [DATA_W-1:0]          ex_v1_o,
  output logic [DATA_W-1:0]          ex_v2_o,
  output logic [ADDR_W-1:0]          ex_pc_o,
  output logic [DATA_W-1:0]          ex_imm_o,
  output logic [ROB_W-1:0]           ex_rob_id_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [OPENUM_W-1:0] op;
    logic [DATA_W-1:0]   v1;
    logic [DATA_W-1:0]   v2;
    logic [ROB_W-1:0]    q1;
    logic [ROB_W-1:0]    q2;
    logic [ADDR_W-1:0]   pc;
    logic [DATA_W-1:0]   imm;
    logic [ROB_W-1:0]    rob;
  } entry_t;

  typedef struct packed {
    logic [OPENUM_W-1:0] op;
    logic [DATA_W-1:0]   v1;
    logic [DATA_W-1:0]   v2;
    logic [ADDR_W-1:0]   pc;
    logic [DATA_W-1:0]   imm;
    logic [ROB_W-1:0]    rob;
  } issue_t;

  // Returns {hit, value}. Scanning from the highest channel down lets the
  // lowest matching channel overwrite last, so it wins on duplicate tags.
  function automatic logic [DATA_W:0] cdb_lookup(
    input logic [ROB_W-1:0]          tag,
    input logic [NUM_CDB-1:0]        valid,
    input logic [NUM_CDB*ROB_W-1:0]  ids,
    input logic [NUM_CDB*DATA_W-1:0] res
  );
    logic [DATA_W:0] hit;
    hit = '0;
    for (int c = int'(NUM_CDB) - 1; c >= 0; c--) begin
      hit = (valid[c] && (tag != ROB_W'(ZERO_ROB)) && (ids[c*ROB_W +: ROB_W] == tag))
            ? {1'b1, res[c*DATA_W +: DATA_W]} : hit;
    end
    return hit;
  endfunction

  logic [DEPTH-1:0] busy_q, busy_d;
  entry_t           ent_q [DEPTH];
  entry_t           ent_d [DEPTH];
  logic             ex_valid_q, ex_valid_d;
  issue_t           ex_q, ex_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [DATA_W:0]  wake1_s [DEPTH];
  logic [DATA_W:0]  wake2_s [DEPTH];
  logic [DATA_W:0]  byp1_s, byp2_s;
  entry_t           disp_ent_s, sel_ent_s;
  logic [DEPTH-1:0] ready_s, free_oh_s, grant_s;
  logic             sel_valid_s, issue_fire_s, disp_fire_s;

  for (genvar g = 0; g < int'(DEPTH); g++) begin : g_entry
    assign wake1_s[g] = cdb_lookup(ent_q[g].q1, cdb_valid_i, cdb_rob_id_i, cdb_result_i);
    assign wake2_s[g] = cdb_lookup(ent_q[g].q2, cdb_valid_i, cdb_rob_id_i, cdb_result_i);
    // Readiness uses registered tags: a wakeup at one edge issues at the next.
    assign ready_s[g] = busy_q[g] & (ent_q[g].q1 == ROB_W'(ZERO_ROB))
                                  & (ent_q[g].q2 == ROB_W'(ZERO_ROB));
  end

  assign byp1_s = cdb_lookup(disp_q1_i, cdb_valid_i, cdb_rob_id_i, cdb_result_i);
  assign byp2_s = cdb_lookup(disp_q2_i, cdb_valid_i, cdb_rob_id_i, cdb_result_i);

  // full and the free slot come from the pre-edge busy vector, so a slot
  // vacated by this edge's issue is not visible to this edge's dispatch.
  assign full_o    = &busy_q;
  assign free_oh_s = ~busy_q & (busy_q + DEPTH'(1));

  assign issue_fire_s = sel_valid_s & (~ex_valid_q | ex_ready_i) & ~flush_i;
  assign disp_fire_s  = disp_valid_i & ~full_o & ~flush_i;

`ifdef RS_OLDEST_FIRST_EN
  logic [DEPTH-1:0]       age_q [DEPTH];
  logic [DEPTH-1:0]       age_d [DEPTH];
  logic [DEPTH*DEPTH-1:0] age_flat_s;

  for (genvar g = 0; g < int'(DEPTH); g++) begin : g_age_flat
    assign age_flat_s[g*DEPTH +: DEPTH] = age_q[g];
  end

  // On insert, the new row marks every occupant as older and the new column
  // is cleared so stale "older" bits from the previous occupant disappear.
  always_comb begin
    for (int k = 0; k < int'(DEPTH); k++) begin
      for (int j = 0; j < int'(DEPTH); j++) begin
        age_d[k][j] = (disp_fire_s && free_oh_s[k]) ? busy_q[j]
                    : ((disp_fire_s && free_oh_s[j]) ? 1'b0 : age_q[k][j]);
      end
    end
  end

  // Age matrix register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int k = 0; k < int'(DEPTH); k++) begin
        age_q[k] <= '0;
      end
    end else begin
      age_q <= age_d;
    end
  end
`endif

  rs_multi_cdb_select #(.DEPTH(DEPTH)) u_select (
`ifdef RS_OLDEST_FIRST_EN
    .age_i   (age_flat_s),
`endif
    .ready_i (ready_s),
    .grant_o (grant_s),
    .valid_o (sel_valid_s)
  );

  // Dispatched entry with same-cycle CDB bypass applied to each operand.
  always_comb begin
    disp_ent_s.op  = disp_openum_i;
    disp_ent_s.v1  = byp1_s[DATA_W] ? byp1_s[DATA_W-1:0] : disp_v1_i;
    disp_ent_s.v2  = byp2_s[DATA_W] ? byp2_s[DATA_W-1:0] : disp_v2_i;
    disp_ent_s.q1  = byp1_s[DATA_W] ? ROB_W'(ZERO_ROB) : disp_q1_i;
    disp_ent_s.q2  = byp2_s[DATA_W] ? ROB_W'(ZERO_ROB) : disp_q2_i;
    disp_ent_s.pc  = disp_pc_i;
    disp_ent_s.imm = disp_imm_i;
    disp_ent_s.rob = disp_rob_id_i;
  end

  // One-hot mux of the granted entry.
  always_comb begin
    sel_ent_s = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      sel_ent_s = sel_ent_s | ({$bits(entry_t){grant_s[i]}} & ent_q[i]);
    end
  end

  // Entry next state: issue frees, CDB wakes busy entries, dispatch fills
  // the free slot (never the same entry as the issue or a wakeup target).
  always_comb begin
    ent_d = ent_q;
    for (int i = 0; i < int'(DEPTH); i++) begin
      ent_d[i].v1 = (busy_q[i] && wake1_s[i][DATA_W]) ? wake1_s[i][DATA_W-1:0] : ent_q[i].v1;
      ent_d[i].q1 = (busy_q[i] && wake1_s[i][DATA_W]) ? ROB_W'(ZERO_ROB) : ent_q[i].q1;
      ent_d[i].v2 = (busy_q[i] && wake2_s[i][DATA_W]) ? wake2_s[i][DATA_W-1:0] : ent_q[i].v2;
      ent_d[i].q2 = (busy_q[i] && wake2_s[i][DATA_W]) ? ROB_W'(ZERO_ROB) : ent_q[i].q2;
      ent_d[i]    = (disp_fire_s && free_oh_s[i]) ? disp_ent_s : ent_d[i];
    end
    busy_d = flush_i ? '0
           : ((busy_q & ~(grant_s & {DEPTH{issue_fire_s}})) | (free_oh_s & {DEPTH{disp_fire_s}}));
  end

  // Output stage next state: load on issue, drain when consumed, else hold.
  always_comb begin
    ex_d = ex_q;
    if (flush_i) begin
      ex_valid_d = 1'b0;
    end else if (issue_fire_s) begin
      ex_valid_d = 1'b1;
      ex_d.op    = sel_ent_s.op;
      ex_d.v1    = sel_ent_s.v1;
      ex_d.v2    = sel_ent_s.v2;
      ex_d.pc    = sel_ent_s.pc;
      ex_d.imm   = sel_ent_s.imm;
      ex_d.rob   = sel_ent_s.rob;
    end else if (ex_ready_i) begin
      ex_valid_d = 1'b0;
    end else begin
      ex_valid_d = ex_valid_q;
    end
    count_d = flush_i ? '0 : (count_q + CNT_W'(disp_fire_s) - CNT_W'(issue_fire_s));
  end

  // State registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      busy_q     <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        ent_q[i] <= '0;
      end
      ex_valid_q <= 1'b0;
      ex_q       <= '{op: OPENUM_W'(OPENUM_NOP), default: '0};
      count_q    <= '0;
    end else begin
      busy_q     <= busy_d;
      ent_q      <= ent_d;
      ex_valid_q <= ex_valid_d;
      ex_q       <= ex_d;
      count_q    <= count_d;
    end
  end

  assign count_o     = count_q;
  assign ex_valid_o  = ex_valid_q;
  assign ex_openum_o = ex_q.op;
  assign ex_v1_o     = ex_q.v1;
  assign ex_v2_o     = ex_q.v2;
  assign ex_pc_o     = ex_q.pc;
  assign ex_imm_o    = ex_q.imm;
  assign ex_rob_id_o = ex_q.rob;

endmodule
